// File: rtl/spi_slave_rx_fifo_wr.sv
// spi_slave_rx_fifo_wr
//
// SPI slave receiver oversampled in the wr_clk domain. sclk, cs_n and mosi
// are synchronised, sclk edges are detected, and MOSI is deserialised into
// DATA_W-bit words. Each completed word is offered to the downstream RX FIFO.
// All four CPOL/CPHA modes are supported. The mode is captured only while
// idle.
//
// Build option:
//   SPI_RX_OVF_CNT_EN  defined   -> saturating overflow counter on ovf_cnt
//                      undefined -> ovf_cnt tied to 0 (ovf pulse still generated)
//
// Ports:
//   wr_clk     system clock, at least 4x the sclk frequency
//   wr_rst     synchronous active-high reset
//   cpol/cpha  SPI mode, captured while idle
//   sclk       SPI clock (asynchronous)
//   cs_n       chip select, active low (asynchronous)
//   mosi       serial data in (asynchronous)
//   wr_full    FIFO full
//   wr_en      FIFO write strobe, one cycle per accepted word
//   rx_data    last completed word, valid while wr_en=1
//   ovf        one-cycle pulse: completed word dropped because the FIFO was full
//   frame_err  one-cycle pulse: chip select released mid-word
//   ovf_cnt    saturating count of ovf pulses
//
// state  | meaning
// -------+------------------------------------------------------------
// IDLE   | not selected; mode tracks cpol/cpha every cycle
// SHIFT  | selected; sample edges shift MOSI in; words wrap back-to-back

module spi_slave_rx_fifo_wr #(
    parameter int DATA_W      = 8,
    parameter int SYNC_STAGES = 2,
    parameter int MSB_FIRST   = 1,
    parameter int OVF_CNT_W   = 8
) (
    input  logic                 wr_clk,
    input  logic                 wr_rst,
    input  logic                 cpol,
    input  logic                 cpha,
    input  logic                 sclk,
    input  logic                 cs_n,
    input  logic                 mosi,
    input  logic                 wr_full,
    output logic                 wr_en,
    output logic [DATA_W-1:0]    rx_data,
    output logic                 ovf,
    output logic                 frame_err,
    output logic [OVF_CNT_W-1:0] ovf_cnt
);

    localparam int CNT_W = $clog2(DATA_W);

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SHIFT = 1'b1
    } state_t;

    state_t                 state_q, state_d;
    logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   sclk_prev_q, sclk_prev_d;
    logic                   mode_cpol_q, mode_cpol_d;
    logic                   mode_cpha_q, mode_cpha_d;
    logic [CNT_W-1:0]       bit_cnt_q, bit_cnt_d;
    logic [DATA_W-1:0]      shift_q, shift_d;
    logic [DATA_W-1:0]      rx_data_q, rx_data_d;
    logic                   commit_q, commit_d;
    logic                   frame_err_q, frame_err_d;

    logic                   sclk_s, cs_s, mosi_s;
    logic                   sclk_rise, sclk_fall;
    logic                   lead_edge, trail_edge, sample_edge;
    logic [DATA_W-1:0]      shift_nxt;

    assign sclk_s = sclk_sync_q[SYNC_STAGES-1];
    assign cs_s   = cs_sync_q[SYNC_STAGES-1];
    assign mosi_s = mosi_sync_q[SYNC_STAGES-1];

    always_comb begin
        sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], sclk};
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], cs_n};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], mosi};
        sclk_prev_d = sclk_s;
    end

    // Edge classification uses the mode latched at the last IDLE cycle,
    // so toggling cpol/cpha mid-transfer has no effect.
    always_comb begin
        sclk_rise   = sclk_s & ~sclk_prev_q;
        sclk_fall   = ~sclk_s & sclk_prev_q;
        lead_edge   = mode_cpol_q ? sclk_fall : sclk_rise;
        trail_edge  = mode_cpol_q ? sclk_rise : sclk_fall;
        sample_edge = mode_cpha_q ? trail_edge : lead_edge;
    end

    always_comb begin
        if (MSB_FIRST != 0) begin
            shift_nxt = {shift_q[DATA_W-2:0], mosi_s};
        end else begin
            shift_nxt = {mosi_s, shift_q[DATA_W-1:1]};
        end
    end

    always_comb begin
        state_d     = state_q;
        mode_cpol_d = mode_cpol_q;
        mode_cpha_d = mode_cpha_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        rx_data_d   = rx_data_q;
        commit_d    = 1'b0;
        frame_err_d = 1'b0;

        case (state_q)
            ST_IDLE: begin
                mode_cpol_d = cpol;
                mode_cpha_d = cpha;
                bit_cnt_d   = '0;
                shift_d     = '0;
                if (!cs_s) begin
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                // Deselect takes priority over a coincident sample edge.
                if (cs_s) begin
                    if (bit_cnt_q != '0) begin
                        frame_err_d = 1'b1;
                    end
                    bit_cnt_d = '0;
                    shift_d   = '0;
                    state_d   = ST_IDLE;
                end else if (sample_edge) begin
                    shift_d = shift_nxt;
                    if (bit_cnt_q == CNT_W'(DATA_W - 1)) begin
                        bit_cnt_d = '0;
                        rx_data_d = shift_nxt;
                        commit_d  = 1'b1;
                    end else begin
                        bit_cnt_d = bit_cnt_q + CNT_W'(1);
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            // Flush the synchronisers to the idle bus level so that no
            // false edge or select is seen on release.
            sclk_sync_q <= {SYNC_STAGES{cpol}};
            cs_sync_q   <= {SYNC_STAGES{1'b1}};
            mosi_sync_q <= '0;
            sclk_prev_q <= cpol;
            state_q     <= ST_IDLE;
            mode_cpol_q <= cpol;
            mode_cpha_q <= cpha;
            bit_cnt_q   <= '0;
            shift_q     <= '0;
            rx_data_q   <= '0;
            commit_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            sclk_sync_q <= sclk_sync_d;
            cs_sync_q   <= cs_sync_d;
            mosi_sync_q <= mosi_sync_d;
            sclk_prev_q <= sclk_prev_d;
            state_q     <= state_d;
            mode_cpol_q <= mode_cpol_d;
            mode_cpha_q <= mode_cpha_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            rx_data_q   <= rx_data_d;
            commit_q    <= commit_d;
            frame_err_q <= frame_err_d;
        end
    end

    // The commit cycle is resolved combinationally so that a late full or
    // deselect still blocks the write in the same cycle.
    assign wr_en     = commit_q & ~wr_full & ~cs_s;
    assign ovf       = commit_q & wr_full;
    assign frame_err = frame_err_q | (commit_q & cs_s & ~wr_full);
    assign rx_data   = rx_data_q;

`ifdef SPI_RX_OVF_CNT_EN
    logic [OVF_CNT_W-1:0] ovf_cnt_q, ovf_cnt_d;

    always_comb begin
        ovf_cnt_d = ovf_cnt_q;
        if (ovf && (ovf_cnt_q != {OVF_CNT_W{1'b1}})) begin
            ovf_cnt_d = ovf_cnt_q + OVF_CNT_W'(1);
        end
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            ovf_cnt_q <= '0;
        end else begin
            ovf_cnt_q <= ovf_cnt_d;
        end
    end

    assign ovf_cnt = ovf_cnt_q;
`else
    assign ovf_cnt = '0;
`endif

endmodule

// File: tb/tb_spi_slave_rx_fifo_wr.sv
// Testbench for spi_slave_rx_fifo_wr. Two instances share the SPI pins:
// dut_m receives MSB first and dut_l receives LSB first. A bit-level SPI
// master drives frames. A word-level model predicts the accepted words,
// the overflow and framing pulses, the held rx_data and the overflow count.
// The expected ovf_cnt follows SPI_RX_OVF_CNT_EN in the same way as the design.

module tb_spi_slave_rx_fifo_wr;

    localparam int H = 4;   // sclk half period in wr_clk cycles

    logic       wr_clk = 1'b0;
    logic       wr_rst;
    logic       cpol, cpha, sclk, cs_n, mosi, wr_full;
    logic       wr_en, ovf, frame_err;
    logic [7:0] rx_data, ovf_cnt;
    logic       wr_en_l, ovf_l, frame_err_l;
    logic [7:0] rx_data_l, ovf_cnt_l;

    always #5 wr_clk = ~wr_clk;

    spi_slave_rx_fifo_wr #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(1), .OVF_CNT_W(8)) dut_m (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .cpol(cpol), .cpha(cpha), .sclk(sclk),
        .cs_n(cs_n), .mosi(mosi), .wr_full(wr_full), .wr_en(wr_en), .rx_data(rx_data),
        .ovf(ovf), .frame_err(frame_err), .ovf_cnt(ovf_cnt)
    );

    spi_slave_rx_fifo_wr #(.DATA_W(8), .SYNC_STAGES(2), .MSB_FIRST(0), .OVF_CNT_W(8)) dut_l (
        .wr_clk(wr_clk), .wr_rst(wr_rst), .cpol(cpol), .cpha(cpha), .sclk(sclk),
        .cs_n(cs_n), .mosi(mosi), .wr_full(wr_full), .wr_en(wr_en_l), .rx_data(rx_data_l),
        .ovf(ovf_l), .frame_err(frame_err_l), .ovf_cnt(ovf_cnt_l)
    );

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed behaviour
    logic [7:0] got_m[$];
    logic [7:0] got_l[$];
    int         got_ovf, got_ferr;

    // Reference model state
    bit         tx_bits[$];
    logic [7:0] exp_m[$];
    logic [7:0] exp_l[$];
    int         exp_ovf, exp_ferr, ovf_total;
    logic [7:0] last_m, last_l;

    always @(negedge wr_clk) begin
        if (!wr_rst) begin
            if (wr_en) begin
                got_m.push_back(rx_data);
                chk("wr_en_guard", {31'b0, cs_n | wr_full}, 32'd0);
            end
            if (wr_en_l) begin
                got_l.push_back(rx_data_l);
                chk("wr_en_guard_lsb", {31'b0, cs_n | wr_full}, 32'd0);
            end
            if (ovf) got_ovf++;
            if (frame_err) got_ferr++;
        end
    end

    function automatic logic [31:0] exp_cnt();
`ifdef SPI_RX_OVF_CNT_EN
        return (ovf_total > 255) ? 32'd255 : 32'(ovf_total);
`else
        return 32'd0;
`endif
    endfunction

    task automatic idle(input int n);
        repeat (n) @(posedge wr_clk);
        #1;
    endtask

    task automatic load_byte(input logic [7:0] v);
        for (int i = 7; i >= 0; i--) tx_bits.push_back(v[i]);
    endtask

    task automatic load_random(input int n);
        for (int i = 0; i < n; i++) tx_bits.push_back(1'($urandom_range(0, 1)));
    endtask

    task automatic start_frame(input logic p, input logic h, input bit scramble);
        cpol = p;
        cpha = h;
        sclk = p;
        cs_n = 1'b1;
        idle(8);
        cs_n = 1'b0;
        idle(H);
        if (scramble) begin
            // The design must ignore mode inputs once selected.
            cpol = 1'($urandom_range(0, 1));
            cpha = 1'($urandom_range(0, 1));
        end
    endtask

    task automatic shift_bits(input logic p, input logic h, input int n);
        for (int i = 0; i < n; i++) begin
            if (!h) begin
                mosi = tx_bits[i];
                idle(H);
                sclk = ~p;
                idle(H);
                sclk = p;
            end else begin
                sclk = ~p;
                mosi = tx_bits[i];
                idle(H);
                sclk = p;
                idle(H);
            end
        end
    endtask

    task automatic end_frame();
        idle(H);
        cs_n = 1'b1;
        idle(12);
    endtask

    task automatic clear_obs();
        got_m.delete();
        got_l.delete();
        got_ovf  = 0;
        got_ferr = 0;
    endtask

    // Sends tx_bits as one selected frame and compares it with the word-level prediction.
    task automatic run_frame(input logic p, input logic h, input bit full, input bit scramble);
        int nbits;
        logic [7:0] m, l;
        nbits = tx_bits.size();
        clear_obs();
        exp_m.delete();
        exp_l.delete();
        exp_ovf  = 0;
        exp_ferr = 0;
        for (int w = 0; w < nbits / 8; w++) begin
            m = '0;
            l = '0;
            for (int i = 0; i < 8; i++) begin
                m[7 - i] = tx_bits[8 * w + i];
                l[i]     = tx_bits[8 * w + i];
            end
            last_m = m;
            last_l = l;
            if (full) begin
                exp_ovf++;
                ovf_total++;
            end else begin
                exp_m.push_back(m);
                exp_l.push_back(l);
            end
        end
        if ((nbits % 8) != 0) exp_ferr = 1;

        wr_full = full;
        start_frame(p, h, scramble);
        shift_bits(p, h, nbits);
        end_frame();
        wr_full = 1'b0;

        chk("n_words", got_m.size(), exp_m.size());
        chk("n_words_lsb", got_l.size(), exp_l.size());
        for (int i = 0; i < exp_m.size() && i < got_m.size(); i++)
            chk("word", got_m[i], exp_m[i]);
        for (int i = 0; i < exp_l.size() && i < got_l.size(); i++)
            chk("word_lsb", got_l[i], exp_l[i]);
        chk("ovf_pulses", got_ovf, exp_ovf);
        chk("frame_err_pulses", got_ferr, exp_ferr);
        chk("rx_data_hold", rx_data, last_m);
        chk("rx_data_hold_lsb", rx_data_l, last_l);
        chk("ovf_cnt", ovf_cnt, exp_cnt());
        chk("ovf_cnt_lsb", ovf_cnt_l, exp_cnt());
        tx_bits.delete();
    endtask

    task automatic check_reset_outputs();
        @(negedge wr_clk);
        chk("rst_wr_en", wr_en, 0);
        chk("rst_rx_data", rx_data, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_frame_err", frame_err, 0);
        chk("rst_ovf_cnt", ovf_cnt, 0);
        chk("rst_rx_data_lsb", rx_data_l, 0);
        idle(1);
    endtask

    initial begin
        wr_rst  = 1'b1;
        cpol    = 1'b0;
        cpha    = 1'b0;
        sclk    = 1'b0;
        cs_n    = 1'b1;
        mosi    = 1'b0;
        wr_full = 1'b0;
        ovf_total = 0;
        last_m  = '0;
        last_l  = '0;
        got_ovf = 0;
        got_ferr = 0;
        idle(4);
        wr_rst = 1'b0;
        check_reset_outputs();

        // Mode 0, single word
        load_byte(8'hA5);
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);

        // Mode 3, back-to-back words under one select
        load_byte(8'h3C);
        load_byte(8'hC3);
        run_frame(1'b1, 1'b1, 1'b0, 1'b0);

        // Mode 1, bit sequence 1,0,0,0,0,0,0,0 (LSB-first instance sees 8'h01)
        load_byte(8'h80);
        run_frame(1'b0, 1'b1, 1'b0, 1'b0);

        // Completed word with the FIFO full
        load_byte(8'h5A);
        run_frame(1'b0, 1'b0, 1'b1, 1'b0);

        // Short frame, then a clean frame
        load_byte(8'hE0);
        void'(tx_bits.pop_back());
        void'(tx_bits.pop_back());
        void'(tx_bits.pop_back());
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);
        load_byte(8'h77);
        run_frame(1'b0, 1'b0, 1'b0, 1'b0);

        // Reset in the middle of a word
        load_random(8);
        start_frame(1'b1, 1'b0, 1'b0);
        shift_bits(1'b1, 1'b0, 4);
        wr_rst = 1'b1;
        cs_n   = 1'b1;
        sclk   = cpol;
        tx_bits.delete();
        idle(3);
        wr_rst = 1'b0;
        ovf_total = 0;
        last_m = '0;
        last_l = '0;
        clear_obs();
        check_reset_outputs();
        idle(10);
        chk("post_rst_frame_err", got_ferr, 0);
        chk("post_rst_wr_en", got_m.size(), 0);
        load_byte(8'h99);
        run_frame(1'b1, 1'b0, 1'b0, 1'b0);

        // Randomised frames: any mode, full words or short frames, FIFO full at random
        for (int f = 0; f < 40; f++) begin
            int nb;
            logic [1:0] md;
            md = 2'($urandom_range(0, 3));
            if ($urandom_range(0, 3) == 0) nb = $urandom_range(1, 23);
            else nb = 8 * $urandom_range(1, 3);
            if ((nb % 8) == 0 && nb > 0) nb = nb;
            load_random(nb);
            run_frame(md[1], md[0], ($urandom_range(0, 3) == 0), 1'b1);
        end

        // Overflow counter saturation: 300 dropped words
        for (int f = 0; f < 30; f++) begin
            logic [1:0] md;
            md = 2'($urandom_range(0, 3));
            load_random(80);
            run_frame(md[1], md[0], 1'b1, 1'b0);
        end
        chk("ovf_cnt_saturated", ovf_cnt, exp_cnt());

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
